// File: rtl/kaipokrandt_cpu_pkg.sv
// kaipokrandt_cpu_pkg: shared state encodings, opcodes and defaults for the control unit
package kaipokrandt_cpu_pkg;
  localparam int DEF_OPCODE_W = 4;
  localparam int DEF_MEM_TIMEOUT = 16;
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_DECODE = 4'd4,
    S_E0     = 4'd5,
    S_E1     = 4'd6,
    S_E2     = 4'd7,
    S_E3     = 4'd8,
    S_HALT   = 4'd9
  } state_t;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_OUT = 4'h5;
  localparam logic [3:0] OP_HLT = 4'hF;
endpackage

// File: rtl/kaipokrandt_mem_watchdog.sv
// kaipokrandt_mem_watchdog: counts memory wait cycles and raises a sticky fault on expiry
module kaipokrandt_mem_watchdog
  import kaipokrandt_cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic in_wait,
  input  logic mem_ready,
  output logic timeout,
  output logic mem_fault
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] count;
  // the last permitted wait cycle without ready ends the wait with a fault
  assign timeout = in_wait && !mem_ready && (count == CW'(MEM_TIMEOUT - 1));
  // count only while still waiting so that leaving the wait state clears it at once
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count     <= '0;
      mem_fault <= 1'b0;
    end else begin
      count     <= (in_wait && !mem_ready) ? count + CW'(1) : '0;
      mem_fault <= mem_fault | timeout;
    end
endmodule

// File: rtl/kaipokrandt_control_unit.sv
// kaipokrandt_control_unit: fetch/decode/execute sequencer for the shared-bus microcontroller
module kaipokrandt_control_unit
  import kaipokrandt_cpu_pkg::*;
#(
  parameter int OPCODE_W    = DEF_OPCODE_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                pc_increment,
  output logic                pc_en,
  output logic                ir_load,
  output logic                ir_en,
  output logic                mar_load,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                mem_en,
  output logic                acc_load,
  output logic                acc_en,
  output logic                b_load,
  output logic                alu_en,
  output logic                alu_sub,
  output logic                out_load,
  output logic                halted,
  output logic                illegal_op,
  output logic                mem_fault,
  output logic [3:0]          state_dbg
);
  state_t state, state_nx;
  logic [OPCODE_W-1:0] op_q;
  logic in_wait, timeout, legal, needs_exec;
  logic is_lda, is_sta, is_sub, is_out;
  assign legal = opcode inside {OPCODE_W'(OP_NOP), OPCODE_W'(OP_LDA), OPCODE_W'(OP_STA),
                                OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB), OPCODE_W'(OP_OUT),
                                OPCODE_W'(OP_HLT)};
  assign needs_exec = opcode inside {OPCODE_W'(OP_LDA), OPCODE_W'(OP_STA), OPCODE_W'(OP_ADD),
                                     OPCODE_W'(OP_SUB), OPCODE_W'(OP_OUT)};
  assign is_lda  = op_q == OPCODE_W'(OP_LDA);
  assign is_sta  = op_q == OPCODE_W'(OP_STA);
  assign is_sub  = op_q == OPCODE_W'(OP_SUB);
  assign is_out  = op_q == OPCODE_W'(OP_OUT);
  assign in_wait = (state == S_T1) || (state == S_E1);
  assign state_dbg = state;
  kaipokrandt_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .in_wait   (in_wait),
    .mem_ready (mem_ready),
    .timeout   (timeout),
    .mem_fault (mem_fault)
  );
  // state register, latched opcode for the execute phase, and the illegal-opcode pulse
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= S_IDLE;
      op_q       <= '0;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_nx;
      op_q       <= (state == S_DECODE) ? opcode : op_q;
      illegal_op <= (state == S_DECODE) && !legal;
    end
  // sequencing; undefined opcodes fall through to the next fetch like NOP
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = S_T0;
      S_T0:     state_nx = S_T1;
      S_T1:     state_nx = timeout ? S_HALT : mem_ready ? S_T2 : S_T1;
      S_T2:     state_nx = S_DECODE;
      S_DECODE: state_nx = (opcode == OPCODE_W'(OP_HLT)) ? S_HALT : needs_exec ? S_E0 : S_T0;
      S_E0:     state_nx = is_out ? S_T0 : S_E1;
      S_E1:     state_nx = timeout ? S_HALT : !mem_ready ? S_E1 : is_sta ? S_T0 : S_E2;
      S_E2:     state_nx = is_lda ? S_T0 : S_E3;
      S_E3:     state_nx = S_T0;
      S_HALT:   state_nx = resume ? S_T0 : S_HALT;
      default:  state_nx = S_IDLE;
    endcase
  end
  // Moore strobe decode; each bus driver is owned by a distinct state/opcode pair
  always_comb begin
    pc_en        = state == S_T0;
    mar_load     = (state == S_T0) || ((state == S_E0) && !is_out);
    mem_rd       = (state == S_T1) || ((state == S_E1) && !is_sta);
    pc_increment = state == S_T2;
    ir_load      = state == S_T2;
    mem_en       = (state == S_T2) || (state == S_E2);
    ir_en        = (state == S_E0) && !is_out;
    acc_en       = ((state == S_E0) && is_out) || ((state == S_E1) && is_sta);
    mem_wr       = (state == S_E1) && is_sta;
    acc_load     = ((state == S_E2) && is_lda) || (state == S_E3);
    b_load       = (state == S_E2) && !is_lda;
    alu_en       = state == S_E3;
    alu_sub      = (state == S_E3) && is_sub;
    out_load     = (state == S_E0) && is_out;
    halted       = state == S_HALT;
  end
endmodule

// File: tb/tb_kaipokrandt_control_unit.sv
// tb_kaipokrandt_control_unit: directed checks of fetch, execute, watchdog, halt and reset
module tb_kaipokrandt_control_unit;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] opcode;
  logic mem_ready, resume;
  logic pc_increment, pc_en, ir_load, ir_en, mar_load, mem_rd, mem_wr, mem_en;
  logic acc_load, acc_en, b_load, alu_en, alu_sub, out_load, halted, illegal_op, mem_fault;
  logic [3:0] state_dbg;
  logic [14:0] strobes;
  int checks = 0;
  int failures = 0;

  localparam logic [14:0] PCI = 15'h4000, PCE = 15'h2000, IRL = 15'h1000, IRE = 15'h0800;
  localparam logic [14:0] MARL = 15'h0400, MRD = 15'h0200, MWR = 15'h0100, MEN = 15'h0080;
  localparam logic [14:0] ACCL = 15'h0040, ACCE = 15'h0020, BL = 15'h0010, ALUE = 15'h0008;
  localparam logic [14:0] SUBF = 15'h0004, OUTL = 15'h0002, HLTF = 15'h0001;

  kaipokrandt_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .resume(resume),
    .pc_increment(pc_increment), .pc_en(pc_en), .ir_load(ir_load), .ir_en(ir_en),
    .mar_load(mar_load), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_en(mem_en),
    .acc_load(acc_load), .acc_en(acc_en), .b_load(b_load), .alu_en(alu_en),
    .alu_sub(alu_sub), .out_load(out_load), .halted(halted), .illegal_op(illegal_op),
    .mem_fault(mem_fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign strobes = {pc_increment, pc_en, ir_load, ir_en, mar_load, mem_rd, mem_wr, mem_en,
                    acc_load, acc_en, b_load, alu_en, alu_sub, out_load, halted};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("bus_one_driver", 32'($countones({pc_en, ir_en, mem_en, acc_en, alu_en}) <= 1), 32'd1);
  endtask

  task automatic step(input string tag, input logic [3:0] st, input logic [14:0] sb);
    tick();
    chk({tag, "_state"}, 32'(state_dbg), 32'(st));
    chk({tag, "_strobes"}, 32'(strobes), 32'(sb));
  endtask

  task automatic fetch_tail(input logic [3:0] op);
    opcode = op;
    mem_ready = 1'b1;
    step("t1", 4'd2, MRD);
    step("t2", 4'd3, MEN | IRL | PCI);
    step("decode", 4'd4, 15'h0);
  endtask

  task automatic fetch(input logic [3:0] op);
    step("t0", 4'd1, PCE | MARL);
    fetch_tail(op);
  endtask

  initial begin
    reset = 1'b0;
    opcode = 4'h0;
    mem_ready = 1'b1;
    resume = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_strobes", 32'(strobes), 32'h0);
      chk("reset_state", 32'(state_dbg), 32'd0);
      chk("reset_flags", 32'({illegal_op, mem_fault}), 32'h0);
    end
    reset = 1'b1;
    fetch(4'h1);
    chk("decode_no_illegal", 32'(illegal_op), 32'd0);
    mem_ready = 1'b0;
    step("lda_e0", 4'd5, IRE | MARL);
    step("lda_e1a", 4'd6, MRD);
    step("lda_e1b", 4'd6, MRD);
    step("lda_e1c", 4'd6, MRD);
    mem_ready = 1'b1;
    step("lda_e2", 4'd7, MEN | ACCL);
    fetch(4'h4);
    step("sub_e0", 4'd5, IRE | MARL);
    step("sub_e1", 4'd6, MRD);
    step("sub_e2", 4'd7, MEN | BL);
    step("sub_e3", 4'd8, ALUE | ACCL | SUBF);
    fetch(4'h3);
    step("add_e0", 4'd5, IRE | MARL);
    step("add_e1", 4'd6, MRD);
    step("add_e2", 4'd7, MEN | BL);
    step("add_e3", 4'd8, ALUE | ACCL);
    fetch(4'h7);
    chk("illegal_at_decode", 32'(illegal_op), 32'd0);
    step("ill_t0", 4'd1, PCE | MARL);
    chk("illegal_pulse", 32'(illegal_op), 32'd1);
    fetch_tail(4'h2);
    chk("illegal_cleared", 32'(illegal_op), 32'd0);
    mem_ready = 1'b0;
    step("sta_e0", 4'd5, IRE | MARL);
    for (int i = 0; i < 16; i++) begin
      step("sta_e1", 4'd6, ACCE | MWR);
      chk("sta_e1_nofault", 32'(mem_fault), 32'd0);
    end
    step("wd_halt", 4'd9, HLTF);
    chk("wd_fault", 32'(mem_fault), 32'd1);
    step("wd_halt_hold", 4'd9, HLTF);
    resume = 1'b1;
    step("wd_resume_t0", 4'd1, PCE | MARL);
    chk("wd_fault_sticky", 32'(mem_fault), 32'd1);
    fetch_tail(4'h5);
    resume = 1'b1;
    step("out_e0", 4'd5, ACCE | OUTL);
    resume = 1'b0;
    fetch(4'hF);
    for (int i = 0; i < 4; i++) step("hlt_hold", 4'd9, HLTF);
    chk("hlt_fault_sticky", 32'(mem_fault), 32'd1);
    resume = 1'b1;
    step("hlt_resume", 4'd1, PCE | MARL);
    resume = 1'b0;
    fetch_tail(4'h1);
    mem_ready = 1'b0;
    step("rst_e0", 4'd5, IRE | MARL);
    step("rst_e1", 4'd6, MRD);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_strobes", 32'(strobes), 32'h0);
    chk("async_rst_state", 32'(state_dbg), 32'd0);
    chk("async_rst_flags", 32'({illegal_op, mem_fault}), 32'h0);
    tick();
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = 4'h0;
    step("restart_t0", 4'd1, PCE | MARL);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/kaipokrandt_control_unit.md
Name: kaipokrandt_control_unit

Overview:
- Fetch/decode/execute sequencer for the 16-bit shared-bus microcontroller.
- Drives the PC's increment and bus-enable inputs, plus the IR, MAR, memory, accumulator, B register, ALU and output register control strobes.
- Guarantees at most one tristate driver on the shared bus per cycle.
- Handles the memory ready handshake with a watchdog timeout, and the halt/resume flow.

Parameters:
- OPCODE_W, 4, width of the opcode field taken from the IR upper bits.
- MEM_TIMEOUT, 16, maximum number of cycles spent waiting for mem_ready before a fault is raised; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  OPCODE_W  instruction opcode from the IR, sampled in DECODE.
- mem_ready  input  1  memory has completed the current read or write.
- resume  input  1  leaves HALT when high.
- pc_increment  output  1  PC increments at the next edge.
- pc_en  output  1  PC drives the bus.
- ir_load  output  1  IR loads from the bus.
- ir_en  output  1  IR operand field drives the bus.
- mar_load  output  1  MAR loads from the bus.
- mem_rd  output  1  memory read request.
- mem_wr  output  1  memory write request; data is taken from the bus.
- mem_en  output  1  memory read data drives the bus.
- acc_load  output  1  accumulator loads from the bus.
- acc_en  output  1  accumulator drives the bus.
- b_load  output  1  B register loads from the bus.
- alu_en  output  1  ALU result drives the bus.
- alu_sub  output  1  ALU subtracts (0 = add).
- out_load  output  1  output register loads from the bus.
- halted  output  1  FSM is in HALT.
- illegal_op  output  1  one-cycle pulse when an undefined opcode is decoded.
- mem_fault  output  1  sticky flag: the memory watchdog expired.
- state_dbg  output  4  current state encoding, for debug.

Behaviour:
- Clock and reset: single clock domain on clk. reset is asynchronous and active-low.
- Reset response: while reset is low, state is IDLE, every output is 0 and the watchdog counter is 0. This applies immediately, including mid-instruction.
- IDLE: transitions to T0 on the first clock after reset deasserts. IDLE is never re-entered except through reset.
- Output decode: Moore outputs, decoded combinationally from the registered state. The exceptions are illegal_op and mem_fault, which are registered.
- Bus invariant: at most one of pc_en, ir_en, mem_en, acc_en, alu_en is high in any cycle.
- Fetch sequence:
  - T0: pc_en, mar_load.
  - T1: mem_rd; hold in T1 until mem_ready=1 is sampled.
  - T2: mem_en, ir_load, pc_increment.
  - DECODE: no strobes; opcode is sampled here.
- Base latency: with mem_ready tied high, fetch takes 4 cycles (T0..DECODE).
- Opcodes (4-bit values shown): 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 OUT, F HLT.
  - Any other opcode behaves as NOP, and illegal_op pulses in the cycle after DECODE.
- NOP: DECODE goes directly to T0.
- LDA:
  - E0: ir_en, mar_load.
  - E1: mem_rd, waiting on mem_ready.
  - E2: mem_en, acc_load.
  - Then T0.
- STA:
  - E0: ir_en, mar_load.
  - E1: acc_en, mem_wr, waiting on mem_ready.
  - Then T0.
- ADD/SUB:
  - E0: ir_en, mar_load.
  - E1: mem_rd, waiting on mem_ready.
  - E2: mem_en, b_load.
  - E3: alu_en, acc_load; alu_sub=1 only for SUB.
  - Then T0.
- OUT: E0 asserts acc_en and out_load, then T0.
- HLT: DECODE goes to HALT. halted=1 and no strobes are asserted.
  - resume=1 in HALT: go to T0.
  - resume is ignored in every other state.
- Memory wait states (T1, and E1 for LDA/STA/ADD/SUB):
  - The watchdog counts cycles spent in the wait state and clears on state exit.
  - If the count reaches MEM_TIMEOUT without mem_ready, mem_fault is set and the FSM goes to HALT.
  - mem_fault is cleared only by reset.
  - resume from a fault-induced HALT restarts fetch at T0 without incrementing the PC.
- mem_ready outside a wait state is ignored.
- mem_ready=1 in the first wait cycle means exactly one wait cycle is spent.
- state_dbg encoding: IDLE=0, T0=1, T1=2, T2=3, DECODE=4, E0=5, E1=6, E2=7, E3=8, HALT=9.

Decomposition:
- Shared package kaipokrandt_cpu_pkg holds:
  - state enum and encodings;
  - opcode constants;
  - OPCODE_W and MEM_TIMEOUT defaults.
- Natural sub-module: kaipokrandt_mem_watchdog, containing the counter, the timeout compare and the sticky fault flag.
- The FSM and output decode stay in this module.

Test Plan:
1. Reset and start: reset low for 3 cycles with mem_ready=1 -> all outputs 0 during reset; the first clock after release is IDLE->T0; T0 shows pc_en=1 and mar_load=1; pc_increment is high in exactly 1 cycle per fetch.
2. LDA with 2 wait cycles: opcode=1, mem_ready high on the 3rd E1 cycle -> E1 lasts 3 cycles, then E2 with mem_en=1 and acc_load=1; instruction total is 4 fetch + 1 + 3 + 1 cycles; the bus invariant holds every cycle.
3. SUB then ADD, mem_ready=1: -> E3 has alu_sub=1 for SUB and alu_sub=0 for ADD; each instruction is 8 cycles.
4. Illegal opcode 7: -> illegal_op high for exactly 1 cycle after DECODE; next state is T0; no load strobes are asserted.
5. Watchdog: STA with mem_ready held 0 and MEM_TIMEOUT=16 -> after 16 E1 cycles, mem_fault=1 and halted=1; resume=1 -> T0; mem_fault stays 1 until reset.
6. HLT and mid-operation reset: opcode=F -> halted=1 indefinitely with resume=0. Separately, assert reset during E1 -> all outputs 0 immediately, without waiting for a clock edge.
